// File: rtl/l1i_pkg.sv
// Shared types and constants for the N-way L1 instruction cache controller.
package l1i_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_COMPARE  = 2'd1,
    ST_ALLOCATE = 2'd2
  } l1i_state_e;

  localparam int unsigned WAY_MIN    = 2;
  localparam int unsigned WAY_MAX    = 8;
  localparam int unsigned PERF_CNT_W = 32;

  // Ceiling log2, usable in constant expressions.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/l1i_nway_controller_if.sv
// Core-side fetch and L2-side refill signal bundle of the L1I controller.
// hit_cnt_o/miss_cnt_o exist only when L1I_PERF_CNT_EN is defined.
interface l1i_nway_controller_if #(
  parameter int unsigned TNUM  = 21,
  parameter int unsigned INUM  = 26 - TNUM,
  parameter int unsigned TNUM2 = 18,
  parameter int unsigned INUM2 = 26 - TNUM2,
  parameter int unsigned WAY   = 4
);
  import l1i_pkg::*;

  localparam int unsigned WAY_W = clog2(WAY);

  logic [TNUM-1:0]  tag_C_L1;
  logic [INUM-1:0]  index_C_L1;
  logic             read_C_L1;
  logic             flush;
  logic             ready_L2_L1;
  logic             stall;
  logic             refill;
  logic             read_L1_L2;
  logic [TNUM2-1:0] tag_L1_L2;
  logic [INUM2-1:0] index_L1_L2;
  logic [WAY_W-1:0] way;
  logic             L1I_miss_o;
  logic             L1I_hit_o;
`ifdef L1I_PERF_CNT_EN
  logic [PERF_CNT_W-1:0] hit_cnt_o;
  logic [PERF_CNT_W-1:0] miss_cnt_o;
`endif

  modport slave (
    input  tag_C_L1, index_C_L1, read_C_L1, flush, ready_L2_L1,
    output stall, refill, read_L1_L2, tag_L1_L2, index_L1_L2, way,
`ifdef L1I_PERF_CNT_EN
    output hit_cnt_o, miss_cnt_o,
`endif
    output L1I_miss_o, L1I_hit_o
  );

  modport master (
    output tag_C_L1, index_C_L1, read_C_L1, flush, ready_L2_L1,
    input  stall, refill, read_L1_L2, tag_L1_L2, index_L1_L2, way,
`ifdef L1I_PERF_CNT_EN
    input  hit_cnt_o, miss_cnt_o,
`endif
    input  L1I_miss_o, L1I_hit_o
  );

endinterface

// File: rtl/l1i_plru.sv
// Tree pseudo-LRU for one set: heap-ordered node bits, bit=0 means the
// victim lies in the lower-numbered half. Purely combinational.
module l1i_plru
  import l1i_pkg::*;
#(
  parameter int unsigned WAY   = 4,
  parameter int unsigned WAY_W = clog2(WAY)
) (
  input  logic [WAY-2:0]   bits_i,
  input  logic [WAY_W-1:0] hit_way_i,
  output logic [WAY-2:0]   next_bits_o,
  output logic [WAY_W-1:0] victim_o
);

  logic [WAY_W:0] leaf;
  logic [WAY_W:0] node;
  logic [WAY_W:0] walk;

  // Every node on the hit way's path is turned to point at the other half.
  always_comb begin
    next_bits_o = bits_i;
    node        = '0;
    leaf        = {1'b1, hit_way_i};
    for (int l = 0; l < int'(WAY_W); l++) begin
      node = leaf >> (int'(WAY_W) - l);
      next_bits_o[WAY_W'(node - 1'b1)] = ~leaf[int'(WAY_W) - 1 - l];
    end
  end

  // Follow the node bits from the root down to a leaf.
  always_comb begin
    walk = (WAY_W + 1)'(1);
    for (int l = 0; l < int'(WAY_W); l++) begin
      walk = {walk[WAY_W-1:0], bits_i[WAY_W'(walk - 1'b1)]};
    end
    victim_o = walk[WAY_W-1:0];
  end

endmodule

// File: rtl/l1i_nway_controller.sv
// N-way set-associative L1 instruction cache tag/valid controller with tree PLRU.
// Define L1I_PERF_CNT_EN to add saturating hit/miss counters.
module l1i_nway_controller
  import l1i_pkg::*;
#(
  parameter int unsigned TNUM  = 21,
  parameter int unsigned INUM  = 26 - TNUM,
  parameter int unsigned TNUM2 = 18,
  parameter int unsigned INUM2 = 26 - TNUM2,
  parameter int unsigned WAY   = 4
) (
  input logic                  clk,
  input logic                  rst,
  l1i_nway_controller_if.slave bus
);

  localparam int unsigned WAY_W = clog2(WAY);
  localparam int unsigned SETS  = 2 ** INUM;

  if (WAY < WAY_MIN || WAY > WAY_MAX || (WAY & (WAY - 1)) != 0) begin : g_bad_way
    $error("l1i_nway_controller: WAY must be a power of two in 2..8");
  end

  l1i_state_e       state_q;
  logic [TNUM-1:0]  req_tag_q;
  logic [INUM-1:0]  req_index_q;
  logic             flush_pend_q;
  logic             refilled_q;
  logic             stall_q, refill_q, read_q, hit_q, miss_q;
  logic [WAY_W-1:0] way_q;

  logic [TNUM-1:0]  tag_q   [SETS][WAY];
  logic [WAY-1:0]   valid_q [SETS];
  logic [WAY-2:0]   plru_q  [SETS];

  logic [WAY-1:0]   match_c;
  logic             hit_c;
  logic [WAY_W-1:0] hit_way_c;
  logic [WAY_W-1:0] inv_way_c;
  logic             has_inv_c;
  logic [WAY_W-1:0] plru_victim_c;
  logic [WAY-2:0]   plru_next_c;
  logic [WAY_W-1:0] victim_c;

  // Parallel tag compare plus lowest-numbered hit and invalid way.
  always_comb begin
    match_c   = '0;
    hit_way_c = '0;
    inv_way_c = '0;
    has_inv_c = 1'b0;
    for (int w = int'(WAY) - 1; w >= 0; w--) begin
      match_c[w] = valid_q[req_index_q][w] && (tag_q[req_index_q][w] == req_tag_q);
      if (match_c[w]) hit_way_c = WAY_W'(w);
      if (!valid_q[req_index_q][w]) begin
        inv_way_c = WAY_W'(w);
        has_inv_c = 1'b1;
      end
    end
  end

  assign hit_c    = |match_c;
  assign victim_c = has_inv_c ? inv_way_c : plru_victim_c;

  l1i_plru #(.WAY(WAY), .WAY_W(WAY_W)) u_plru (
    .bits_i      (plru_q[req_index_q]),
    .hit_way_i   (hit_way_c),
    .next_bits_o (plru_next_c),
    .victim_o    (plru_victim_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      req_tag_q    <= '0;
      req_index_q  <= '0;
      flush_pend_q <= 1'b0;
      refilled_q   <= 1'b0;
      stall_q      <= 1'b0;
      refill_q     <= 1'b0;
      read_q       <= 1'b0;
      hit_q        <= 1'b0;
      miss_q       <= 1'b0;
      way_q        <= '0;
      for (int s = 0; s < int'(SETS); s++) begin
        valid_q[s] <= '0;
        plru_q[s]  <= '0;
        for (int w = 0; w < int'(WAY); w++) tag_q[s][w] <= '0;
      end
    end else begin
      hit_q    <= 1'b0;
      miss_q   <= 1'b0;
      refill_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          // A flush (new or deferred) wins over a fetch in the same cycle.
          if (bus.flush || flush_pend_q) begin
            for (int s = 0; s < int'(SETS); s++) valid_q[s] <= '0;
            flush_pend_q <= 1'b0;
          end else if (bus.read_C_L1) begin
            req_tag_q   <= bus.tag_C_L1;
            req_index_q <= bus.index_C_L1;
            refilled_q  <= 1'b0;
            stall_q     <= 1'b1;
            state_q     <= ST_COMPARE;
          end
        end
        ST_COMPARE: begin
          if (bus.flush) flush_pend_q <= 1'b1;
          if (hit_c) begin
            hit_q               <= 1'b1;
            way_q               <= hit_way_c;
            plru_q[req_index_q] <= plru_next_c;
            stall_q             <= 1'b0;
            state_q             <= ST_IDLE;
          end else begin
            // The compare that follows a refill never reports a miss.
            miss_q  <= ~refilled_q;
            way_q   <= victim_c;
            read_q  <= 1'b1;
            state_q <= ST_ALLOCATE;
          end
        end
        ST_ALLOCATE: begin
          if (bus.flush) flush_pend_q <= 1'b1;
          if (bus.ready_L2_L1) begin
            tag_q[req_index_q][way_q]   <= req_tag_q;
            valid_q[req_index_q][way_q] <= 1'b1;
            refill_q                    <= 1'b1;
            refilled_q                  <= 1'b1;
            read_q                      <= 1'b0;
            state_q                     <= ST_COMPARE;
          end
        end
        default: begin
          stall_q <= 1'b0;
          read_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.stall      = stall_q;
  assign bus.refill     = refill_q;
  assign bus.read_L1_L2 = read_q;
  assign bus.way        = way_q;
  assign bus.L1I_hit_o  = hit_q;
  assign bus.L1I_miss_o = miss_q;
  assign bus.tag_L1_L2  = req_tag_q[TNUM-1 -: TNUM2];

  if (TNUM2 < TNUM) begin : g_idx_split
    assign bus.index_L1_L2 = INUM2'({req_tag_q[TNUM-TNUM2-1:0], req_index_q});
  end else begin : g_idx_plain
    assign bus.index_L1_L2 = INUM2'(req_index_q);
  end

`ifdef L1I_PERF_CNT_EN
  logic [PERF_CNT_W-1:0] hit_cnt_q;
  logic [PERF_CNT_W-1:0] miss_cnt_q;

  // Saturating event counters driven by the registered hit/miss pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (hit_q && (hit_cnt_q != '1))   hit_cnt_q  <= hit_cnt_q + PERF_CNT_W'(1);
      if (miss_q && (miss_cnt_q != '1)) miss_cnt_q <= miss_cnt_q + PERF_CNT_W'(1);
    end
  end

  assign bus.hit_cnt_o  = hit_cnt_q;
  assign bus.miss_cnt_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_l1i_nway_controller.sv
// Directed + random bench for l1i_nway_controller against a timestamp-based LRU-tree model.
module tb_l1i_nway_controller;

  localparam int unsigned TNUM  = 21;
  localparam int unsigned INUM  = 5;
  localparam int unsigned TNUM2 = 18;
  localparam int unsigned INUM2 = 8;
  localparam int unsigned WAY   = 4;
  localparam int unsigned SETS  = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  l1i_nway_controller_if #(.TNUM(TNUM), .INUM(INUM), .TNUM2(TNUM2), .INUM2(INUM2), .WAY(WAY)) bus ();

  l1i_nway_controller #(.TNUM(TNUM), .INUM(INUM), .TNUM2(TNUM2), .INUM2(INUM2), .WAY(WAY)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference state: tags, valids, and last-hit time per way.
  logic [TNUM-1:0] mtag   [SETS][WAY];
  bit              mvalid [SETS][WAY];
  int              mstamp [SETS][WAY];
  int              tick;
  int              n_hit, n_miss;
  logic [TNUM-1:0] pool [6];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int s = 0; s < int'(SETS); s++)
      for (int w = 0; w < int'(WAY); w++) begin
        mvalid[s][w] = 1'b0;
        mstamp[s][w] = 0;
        mtag[s][w]   = '0;
      end
    tick = 0; n_hit = 0; n_miss = 0;
  endtask

  task automatic model_flush();
    for (int s = 0; s < int'(SETS); s++)
      for (int w = 0; w < int'(WAY); w++) mvalid[s][w] = 1'b0;
  endtask

  // Lowest invalid way, else descend into whichever half was used less recently.
  function automatic int model_victim(input int s);
    int lo, size, half, ml, mr;
    for (int w = 0; w < int'(WAY); w++) if (!mvalid[s][w]) return w;
    lo = 0; size = WAY;
    while (size > 1) begin
      half = size / 2; ml = 0; mr = 0;
      for (int i = 0; i < half; i++) begin
        if (mstamp[s][lo+i] > ml)      ml = mstamp[s][lo+i];
        if (mstamp[s][lo+half+i] > mr) mr = mstamp[s][lo+half+i];
      end
      if (mr < ml) lo = lo + half;
      size = half;
    end
    return lo;
  endfunction

  // One complete fetch from IDLE back to IDLE, checking every visible step.
  task automatic do_read(input logic [TNUM-1:0] t, input logic [INUM-1:0] s,
                         input int dly_in, input bit fl_alloc);
    bit hit; int hw, vic, dly;
    hit = 1'b0; hw = 0; dly = dly_in;
    if (fl_alloc && dly == 0) dly = 1;
    for (int w = 0; w < int'(WAY); w++)
      if (!hit && mvalid[s][w] && mtag[s][w] == t) begin hit = 1'b1; hw = w; end
    bus.tag_C_L1 = t; bus.index_C_L1 = s; bus.read_C_L1 = 1'b1;
    step();
    bus.read_C_L1 = 1'b0;
    bus.tag_C_L1 = TNUM'($urandom); bus.index_C_L1 = INUM'($urandom);
    chk("cmp_stall", 32'(bus.stall), 32'd1);
    chk("cmp_hit_early", 32'(bus.L1I_hit_o), 32'd0);
    step();
    if (hit) begin
      chk("hit_pulse", 32'(bus.L1I_hit_o), 32'd1);
      chk("hit_nomiss", 32'(bus.L1I_miss_o), 32'd0);
      chk("hit_way", 32'(bus.way), 32'(hw));
      chk("hit_stall", 32'(bus.stall), 32'd0);
      mstamp[s][hw] = ++tick; n_hit++;
    end else begin
      vic = model_victim(s);
      chk("miss_pulse", 32'(bus.L1I_miss_o), 32'd1);
      chk("miss_nohit", 32'(bus.L1I_hit_o), 32'd0);
      chk("miss_way", 32'(bus.way), 32'(vic));
      chk("miss_rd", 32'(bus.read_L1_L2), 32'd1);
      chk("miss_tag2", 32'(bus.tag_L1_L2), 32'(t >> (TNUM - TNUM2)));
      chk("miss_idx2", 32'(bus.index_L1_L2), 32'({t[TNUM-TNUM2-1:0], s}));
      n_miss++;
      for (int k = 0; k < dly; k++) begin
        bus.read_C_L1 = 1'b1;
        if (fl_alloc && k == 0) bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        chk("alloc_rd", 32'(bus.read_L1_L2), 32'd1);
        chk("alloc_nomiss", 32'(bus.L1I_miss_o), 32'd0);
        chk("alloc_way", 32'(bus.way), 32'(vic));
      end
      bus.read_C_L1 = 1'b0; bus.ready_L2_L1 = 1'b1;
      step();
      bus.ready_L2_L1 = 1'b0;
      chk("refill_pulse", 32'(bus.refill), 32'd1);
      chk("refill_rd", 32'(bus.read_L1_L2), 32'd0);
      chk("refill_stall", 32'(bus.stall), 32'd1);
      chk("refill_nomiss", 32'(bus.L1I_miss_o), 32'd0);
      mtag[s][vic] = t; mvalid[s][vic] = 1'b1;
      step();
      chk("post_hit", 32'(bus.L1I_hit_o), 32'd1);
      chk("post_nomiss", 32'(bus.L1I_miss_o), 32'd0);
      chk("post_way", 32'(bus.way), 32'(vic));
      chk("post_refill_low", 32'(bus.refill), 32'd0);
      mstamp[s][vic] = ++tick; n_hit++;
    end
  endtask

  initial begin
    logic [TNUM-1:0] t5, tw2, tw0;
    bus.tag_C_L1 = '0; bus.index_C_L1 = '0; bus.read_C_L1 = 1'b0;
    bus.flush = 1'b0; bus.ready_L2_L1 = 1'b0;
    model_reset();
    for (int i = 0; i < 6; i++) pool[i] = TNUM'($urandom);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", 32'(bus.stall), 32'd0);
    chk("rst_refill", 32'(bus.refill), 32'd0);
    chk("rst_rd", 32'(bus.read_L1_L2), 32'd0);
    chk("rst_hit", 32'(bus.L1I_hit_o), 32'd0);
    chk("rst_miss", 32'(bus.L1I_miss_o), 32'd0);
    chk("rst_way", 32'(bus.way), 32'd0);
    chk("rst_tag2", 32'(bus.tag_L1_L2), 32'd0);
    chk("rst_idx2", 32'(bus.index_L1_L2), 32'd0);
    rst = 1'b0;
    step();

    // Cold miss, 3-cycle L2 latency, lands in way 0.
    do_read(21'h1A2B3, 5'd5, 3, 1'b0);
    chk("cold_way0", 32'(mtag[5][0]), 32'h1A2B3);

    // Fill set 5, then a fifth tag evicts the PLRU way; the evicted tag misses again.
    do_read(21'h00111, 5'd5, 1, 1'b0);
    do_read(21'h00222, 5'd5, 0, 1'b0);
    do_read(21'h00333, 5'd5, 2, 1'b0);
    do_read(21'h00444, 5'd5, 1, 1'b0);
    do_read(21'h1A2B3, 5'd5, 1, 1'b0);

    // Hit way 2 then way 0, then a new tag.
    tw2 = mtag[5][2]; tw0 = mtag[5][0];
    do_read(tw2, 5'd5, 0, 1'b0);
    do_read(tw0, 5'd5, 0, 1'b0);
    do_read(21'h00555, 5'd5, 1, 1'b0);

    // Random traffic over two sets with a small tag pool.
    for (int i = 0; i < 40; i++)
      do_read(pool[$urandom_range(0, 5)], INUM'(8 + $urandom_range(0, 1)), int'($urandom_range(0, 3)), 1'b0);

    // Flush in IDLE beats a simultaneous read.
    t5 = mtag[5][1];
    bus.flush = 1'b1; bus.read_C_L1 = 1'b1; bus.tag_C_L1 = t5; bus.index_C_L1 = 5'd5;
    step();
    bus.flush = 1'b0; bus.read_C_L1 = 1'b0;
    chk("flush_read_ignored", 32'(bus.stall), 32'd0);
    model_flush();
    do_read(t5, 5'd5, 1, 1'b0);

    // Flush during ALLOCATE is deferred until IDLE.
    do_read(21'h0F0F0, 5'd6, 2, 1'b1);
    bus.read_C_L1 = 1'b1; bus.tag_C_L1 = 21'h0F0F0; bus.index_C_L1 = 5'd6;
    step();
    bus.read_C_L1 = 1'b0;
    chk("pend_flush_read_ignored", 32'(bus.stall), 32'd0);
    model_flush();
    do_read(21'h0F0F0, 5'd6, 1, 1'b0);

    // Reset in the middle of ALLOCATE.
    bus.tag_C_L1 = 21'h0ABCD; bus.index_C_L1 = 5'd3; bus.read_C_L1 = 1'b1;
    step();
    bus.read_C_L1 = 1'b0;
    step();
    chk("pre_rst_alloc", 32'(bus.read_L1_L2), 32'd1);
    step();
    #3 rst = 1'b1;
    #1;
    chk("rst_mid_stall", 32'(bus.stall), 32'd0);
    chk("rst_mid_rd", 32'(bus.read_L1_L2), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    step();

    // Three misses and five hits since reset.
    do_read(21'h07001, 5'd7, 1, 1'b0);
    do_read(21'h07002, 5'd7, 0, 1'b0);
    do_read(21'h07003, 5'd7, 2, 1'b0);
    do_read(21'h07001, 5'd7, 0, 1'b0);
    do_read(21'h07002, 5'd7, 0, 1'b0);
    step();
`ifdef L1I_PERF_CNT_EN
    chk("hit_cnt", bus.hit_cnt_o, 32'(n_hit));
    chk("miss_cnt", bus.miss_cnt_o, 32'(n_miss));
`endif

    // Previously cached lines are gone after reset.
    do_read(t5, 5'd5, 1, 1'b0);
    do_read(pool[0], 5'd8, 1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
